// File: rtl/phys_freelist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phys_freelist_pkg
// Description : Shared constants and tag types for the rename free lists.
//               GPR list: 32 physical / 16 architectural tags.
//               T-bit list: 16 physical / 1 architectural tag.
// Revision    : 1.0 - initial release
// ============================================================================
package phys_freelist_pkg;

    localparam int GPR_PHYS = 32;
    localparam int GPR_ARCH = 16;
    localparam int T_PHYS   = 16;
    localparam int T_ARCH   = 1;

    // Rename width: tags allocated / returned per cycle
    localparam int WIDTH    = 2;

    typedef logic [4:0] preg_t;
    typedef logic [3:0] ttag_t;

endpackage : phys_freelist_pkg
`default_nettype wire

// File: rtl/phys_freelist_if.sv
`default_nettype none
// ============================================================================
// Module      : phys_freelist_if
// Description : Rename / retire side bundle of the physical tag free list.
//               master : rename + retire logic (drives requests, frees)
//               slave  : free list (drives grants, tags, counts)
//   recovery_en  : flush, rewind allocation to committed point
//   alloc_req    : per-slot allocation requests (slot 0 older)
//   freelist_en  : per-slot granted allocations
//   next_free    : tags at head and head+1
//   alloc_stall  : not enough free tags for the request
//   free_en/tag  : tags returned at retirement
//   commit_alloc : retiring instructions that had allocated
//   free_count   : free tags available for allocation
// Revision    : 1.0 - initial release
// ============================================================================
interface phys_freelist_if
    import phys_freelist_pkg::*;
#(
    parameter int N_PHYS = GPR_PHYS
) ();
    localparam int TAG_W = $clog2(N_PHYS);
    localparam int PTR_W = TAG_W + 1;

    logic                         recovery_en;
    logic [WIDTH-1:0]             alloc_req;
    logic [WIDTH-1:0]             freelist_en;
    logic [WIDTH-1:0][TAG_W-1:0]  next_free;
    logic                         alloc_stall;
    logic [WIDTH-1:0]             free_en;
    logic [WIDTH-1:0][TAG_W-1:0]  free_tag;
    logic [WIDTH-1:0]             commit_alloc;
    logic [PTR_W-1:0]             free_count;

    modport master (
        output recovery_en, alloc_req, free_en, free_tag, commit_alloc,
        input  freelist_en, next_free, alloc_stall, free_count
    );

    modport slave (
        input  recovery_en, alloc_req, free_en, free_tag, commit_alloc,
        output freelist_en, next_free, alloc_stall, free_count
    );

endinterface : phys_freelist_if
`default_nettype wire

// File: rtl/phys_freelist_popcount2.sv
`default_nettype none
// ============================================================================
// Module      : phys_freelist_popcount2
// Description : Population count of a 2-bit vector (0..2).
//   bits  : input vector
//   count : number of set bits
// Revision    : 1.0 - initial release
// ============================================================================
module phys_freelist_popcount2 (
    input  wire logic [1:0] bits,
    output logic      [1:0] count
);
    assign count = {bits[1] & bits[0], bits[1] ^ bits[0]};
endmodule : phys_freelist_popcount2
`default_nettype wire

// File: rtl/phys_freelist.sv
`default_nettype none
// ============================================================================
// Module      : phys_freelist
// Description : Circular free list of physical register tags for rename.
//               Two tags offered per cycle at head/head+1, old tags
//               reclaimed at tail on retirement, and on recovery head is
//               rewound to the committed allocation point.
//   clk, rst : clock, synchronous active-high reset
//   fl       : phys_freelist_if slave port (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module phys_freelist
    import phys_freelist_pkg::*;
#(
    parameter int N_PHYS = GPR_PHYS,
    parameter int N_ARCH = GPR_ARCH,
    parameter int TAG_W  = $clog2(N_PHYS),
    parameter int PTR_W  = TAG_W + 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    phys_freelist_if.slave  fl
);

    localparam logic [PTR_W-1:0] INIT_FREE = PTR_W'(N_PHYS - N_ARCH);

    logic [TAG_W-1:0] mem [N_PHYS];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] commit_head;
    logic [PTR_W-1:0] tail;

    logic [1:0]       need;
    logic [1:0]       grant_cnt;
    logic [1:0]       free_cnt;
    logic [1:0]       commit_cnt;
    logic [1:0]       grant;
    logic             stall;
    logic [PTR_W-1:0] free_count;
    logic [PTR_W-1:0] commit_next;
    logic [TAG_W-1:0] wr_idx0;
    logic [TAG_W-1:0] wr_idx1;
    logic [TAG_W-1:0] rd_idx0;
    logic [TAG_W-1:0] rd_idx1;

    phys_freelist_popcount2 u_pc_need   (.bits(fl.alloc_req),    .count(need));
    phys_freelist_popcount2 u_pc_grant  (.bits(grant),           .count(grant_cnt));
    phys_freelist_popcount2 u_pc_free   (.bits(fl.free_en),      .count(free_cnt));
    phys_freelist_popcount2 u_pc_commit (.bits(fl.commit_alloc), .count(commit_cnt));

    assign free_count  = tail - head;
    assign commit_next = commit_head + PTR_W'(commit_cnt);

    // Frees are not bypassed: only tags already present at the start of
    // the cycle count toward the stall decision.
    assign stall = (PTR_W'(need) > free_count) && !fl.recovery_en && !rst;
    assign grant = (stall || fl.recovery_en || rst) ? 2'b00 : fl.alloc_req;

    assign rd_idx0 = head[TAG_W-1:0];
    assign rd_idx1 = head[TAG_W-1:0] + TAG_W'(1);

    // Slot 1 packs behind slot 0 only when slot 0 is also freeing
    assign wr_idx0 = tail[TAG_W-1:0];
    assign wr_idx1 = tail[TAG_W-1:0] + TAG_W'(fl.free_en[0]);

    assign fl.freelist_en  = grant;
    assign fl.alloc_stall  = stall;
    assign fl.free_count   = free_count;
    assign fl.next_free[0] = mem[rd_idx0];
    assign fl.next_free[1] = mem[rd_idx1];

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= INIT_FREE;
        end else begin
            commit_head <= commit_next;
            tail        <= tail + PTR_W'(free_cnt);
            // Retirement still advances during a flush, so the rewind
            // target includes this cycle's commits.
            if (fl.recovery_en) begin
                head <= commit_next;
            end else begin
                head <= head + PTR_W'(grant_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PHYS; i++) begin
                mem[i] <= (i < N_PHYS - N_ARCH) ? TAG_W'(N_ARCH + i) : '0;
            end
        end else begin
            if (fl.free_en[0]) begin
                mem[wr_idx0] <= fl.free_tag[0];
            end
            if (fl.free_en[1]) begin
                mem[wr_idx1] <= fl.free_tag[1];
            end
        end
    end

`ifndef SYNTHESIS
    a_free_overflow : assert property (@(posedge clk) disable iff (rst)
        (free_count + PTR_W'(free_cnt)) <= INIT_FREE)
        else $error("phys_freelist: free would exceed list capacity");

    a_commit_past_head : assert property (@(posedge clk) disable iff (rst)
        (head - commit_head) >= PTR_W'(commit_cnt))
        else $error("phys_freelist: commit_alloc passes head");

    a_req_order : assert property (@(posedge clk) disable iff (rst)
        !(fl.alloc_req[1] && !fl.alloc_req[0]))
        else $error("phys_freelist: alloc_req[1] without alloc_req[0]");
`endif

endmodule : phys_freelist
`default_nettype wire

// File: tb/tb_phys_freelist.sv
`default_nettype none
// ============================================================================
// Module      : tb_phys_freelist
// Description : Directed checks of the GPR free list plus a modelled
//               random alloc/retire run on the T-bit free list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phys_freelist;
    import phys_freelist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    phys_freelist_if #(.N_PHYS(GPR_PHYS)) g_if ();
    phys_freelist_if #(.N_PHYS(T_PHYS))   t_if ();

    phys_freelist #(.N_PHYS(GPR_PHYS), .N_ARCH(GPR_ARCH)) u_gpr (
        .clk (clk),
        .rst (rst),
        .fl  (g_if.slave)
    );

    phys_freelist #(.N_PHYS(T_PHYS), .N_ARCH(T_ARCH)) u_tbit (
        .clk (clk),
        .rst (rst),
        .fl  (t_if.slave)
    );

    // T-bit reference model
    int    fq[$];
    int    inflight[$];
    int    mapped;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int in_use(input int t);
        int n = 0;
        foreach (inflight[i]) if (inflight[i] == t) n++;
        if (mapped == t) n++;
        return n;
    endfunction

    task automatic g_idle();
        g_if.recovery_en  = 1'b0;
        g_if.alloc_req    = 2'b00;
        g_if.free_en      = 2'b00;
        g_if.free_tag     = '0;
        g_if.commit_alloc = 2'b00;
    endtask

    initial begin
        int ret, need, fc, g0, g1, f0, f1, c0, c1;
        logic [1:0] req;

        g_idle();
        t_if.recovery_en  = 1'b0;
        t_if.alloc_req    = 2'b00;
        t_if.free_en      = 2'b00;
        t_if.free_tag     = '0;
        t_if.commit_alloc = 2'b00;

        // ---- reset, with a request held to confirm it is masked ----
        rst = 1'b1;
        g_if.alloc_req = 2'b11;
        tick();
        #2;
        chk("rst_en",    int'(g_if.freelist_en), 0);
        chk("rst_stall", int'(g_if.alloc_stall), 0);
        tick();
        rst = 1'b0;
        g_if.alloc_req = 2'b00;
        #2;
        chk("idle_cnt",   int'(g_if.free_count),   16);
        chk("idle_nf0",   int'(g_if.next_free[0]), 16);
        chk("idle_nf1",   int'(g_if.next_free[1]), 17);
        chk("idle_stall", int'(g_if.alloc_stall),  0);
        chk("idle_en",    int'(g_if.freelist_en),  0);

        // ---- drain with dual allocations ----
        for (int i = 0; i < 8; i++) begin
            g_if.alloc_req = 2'b11;
            #2;
            chk("drain_en",  int'(g_if.freelist_en),  3);
            chk("drain_nf0", int'(g_if.next_free[0]), 16 + 2 * i);
            chk("drain_nf1", int'(g_if.next_free[1]), 17 + 2 * i);
            tick();
        end
        #2;
        chk("empty_cnt",   int'(g_if.free_count),  0);
        chk("empty_stall", int'(g_if.alloc_stall), 1);
        chk("empty_en",    int'(g_if.freelist_en), 0);
        tick();
        g_if.alloc_req = 2'b00;
        #2;
        chk("empty_hold", int'(g_if.free_count), 0);

        // ---- free at empty is not bypassed ----
        g_if.free_en     = 2'b01;
        g_if.free_tag[0] = 5'd5;
        g_if.alloc_req   = 2'b01;
        #2;
        chk("nobyp_stall", int'(g_if.alloc_stall), 1);
        chk("nobyp_en",    int'(g_if.freelist_en), 0);
        tick();
        g_if.free_en = 2'b00;
        #2;
        chk("byp_cnt",   int'(g_if.free_count),   1);
        chk("byp_nf0",   int'(g_if.next_free[0]), 5);
        chk("byp_en",    int'(g_if.freelist_en),  1);
        chk("byp_stall", int'(g_if.alloc_stall),  0);
        tick();
        g_if.alloc_req = 2'b00;
        #2;
        chk("byp_after", int'(g_if.free_count), 0);

        // ---- recovery rewinds to commit point ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            g_if.alloc_req = 2'b11;
            tick();
        end
        g_if.alloc_req    = 2'b00;
        g_if.commit_alloc = 2'b11;
        tick();
        g_if.commit_alloc = 2'b00;
        g_if.recovery_en  = 1'b1;
        g_if.alloc_req    = 2'b11;
        #2;
        chk("rec_en",    int'(g_if.freelist_en), 0);
        chk("rec_stall", int'(g_if.alloc_stall), 0);
        tick();
        g_idle();
        #2;
        chk("rec_cnt", int'(g_if.free_count),   14);
        chk("rec_nf0", int'(g_if.next_free[0]), 18);
        chk("rec_nf1", int'(g_if.next_free[1]), 19);

        // ---- recovery with coincident frees and a commit ----
        g_if.alloc_req = 2'b11;
        #2;
        chk("pre_en", int'(g_if.freelist_en), 3);
        tick();
        g_if.alloc_req    = 2'b00;
        g_if.recovery_en  = 1'b1;
        g_if.free_en      = 2'b11;
        g_if.free_tag[0]  = 5'd3;
        g_if.free_tag[1]  = 5'd4;
        g_if.commit_alloc = 2'b01;
        #2;
        chk("recf_en", int'(g_if.freelist_en), 0);
        tick();
        g_idle();
        #2;
        chk("recf_cnt", int'(g_if.free_count),   15);
        chk("recf_nf0", int'(g_if.next_free[0]), 19);
        for (int i = 0; i < 6; i++) begin
            g_if.alloc_req = 2'b11;
            tick();
        end
        g_if.alloc_req = 2'b00;
        #2;
        chk("tail_cnt", int'(g_if.free_count),   3);
        chk("tail_nf0", int'(g_if.next_free[0]), 31);
        chk("tail_nf1", int'(g_if.next_free[1]), 3);
        g_if.alloc_req = 2'b11;
        tick();
        g_if.alloc_req = 2'b00;
        #2;
        chk("tail2_cnt", int'(g_if.free_count),   1);
        chk("tail2_nf0", int'(g_if.next_free[0]), 4);

        // ---- T-bit list: random allocate / retire against a model ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fq.delete();
        inflight.delete();
        for (int t = 1; t < T_PHYS; t++) fq.push_back(t);
        mapped = 0;

        for (int cyc = 0; cyc < 100; cyc++) begin
            // Retire: each retiring T-writer frees the previous mapping.
            ret = int'($urandom_range(0, 2));
            if (ret > inflight.size()) ret = inflight.size();
            f0 = 0; f1 = 0;
            if (ret >= 1) begin
                c0 = inflight.pop_front();
                f0 = mapped;
                mapped = c0;
            end
            if (ret == 2) begin
                c1 = inflight.pop_front();
                f1 = mapped;
                mapped = c1;
            end
            t_if.free_en      = (ret == 2) ? 2'b11 : (ret == 1) ? 2'b01 : 2'b00;
            t_if.commit_alloc = t_if.free_en;
            t_if.free_tag[0]  = 4'(f0);
            t_if.free_tag[1]  = 4'(f1);

            case ($urandom_range(0, 3))
                0:       req = 2'b00;
                1:       req = 2'b01;
                default: req = 2'b11;
            endcase
            need = int'(req[0]) + int'(req[1]);
            t_if.alloc_req = req;
            #2;
            fc = fq.size();
            chk("t_cnt", int'(t_if.free_count), fc);
            chk("t_cap", int'(t_if.free_count) <= 15 ? 1 : 0, 1);
            if (fc > 0) chk("t_nf0", int'(t_if.next_free[0]), fq[0]);
            if (fc > 1) chk("t_nf1", int'(t_if.next_free[1]), fq[1]);
            chk("t_en", int'(t_if.freelist_en), (need <= fc) ? int'(req) : 0);
            if (need <= fc) begin
                if (req[0]) begin
                    chk("t_dup0", in_use(int'(t_if.next_free[0])), 0);
                    g0 = fq.pop_front();
                    inflight.push_back(g0);
                end
                if (req[1]) begin
                    chk("t_dup1", in_use(int'(t_if.next_free[1])), 0);
                    g1 = fq.pop_front();
                    inflight.push_back(g1);
                end
            end
            if (ret >= 1) fq.push_back(f0);
            if (ret == 2) fq.push_back(f1);
            tick();
        end
        t_if.alloc_req    = 2'b00;
        t_if.free_en      = 2'b00;
        t_if.commit_alloc = 2'b00;
        #2;
        chk("t_end_cnt", int'(t_if.free_count), fq.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_phys_freelist
`default_nettype wire
